rx_byte_buffer: RTL and testbench

RX_BYTE_BUFFER -- requirements
Module: rx_byte_buffer

---
 rtl/rx_buf_pkg.sv | 5 +
 rtl/rx_fifo.sv | 41 ++++
 rtl/rx_byte_buffer.sv | 71 +++++++
 tb/tb_rx_byte_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rx_buf_pkg.sv
// rx_buf_pkg: shared handshake state type and FIFO depth default for the rx byte buffer
package rx_buf_pkg;
  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;
  localparam int DEPTH_DEF = 4;
endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: byte FIFO with wrap-around pointers, occupancy count and zero-when-empty head
// Ports: hz100 clock, reset async active-low, push/pop requests, din write byte,
//        dout head byte (8'h00 when empty), count occupancy, full, empty.
module rx_fifo
  import rx_buf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     hz100,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic wen, ren;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign ren = pop && !empty;
  // a write into a full FIFO is allowed only when the head frees a slot on the same edge
  assign wen = push && (!full || ren);
  always_ff @(posedge hz100 or negedge reset)
    if (!reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (wen) wr <= wr + 1'b1;
      if (ren) rd <= rd + 1'b1;
      count <= count + (AW+1)'(wen) - (AW+1)'(ren);
    end
  always_ff @(posedge hz100)
    if (wen) mem[wr] <= din;
  assign dout = empty ? 8'h00 : mem[rd];
endmodule

// File: rtl/rx_byte_buffer.sv
// rx_byte_buffer: receiver handshake FSM feeding a byte FIFO drained by a pushbutton pop
// Ports: hz100 clock, reset async active-low, rxdata/rxready from receiver, rxclk ack pulse,
//        pop level request (rising edge acts), dout/valid/count FIFO head state,
//        overflow and perr sticky flags.
// Build option: define RX_PARITY_EN to check even parity in rxdata[7] and store 7-bit bytes.
module rx_byte_buffer
  import rx_buf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   hz100,
  input  logic                   reset,
  input  logic [7:0]             rxdata,
  input  logic                   rxready,
  output logic                   rxclk,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   perr
);
  state_t state, state_nx;
  logic pop_q, pop_edge, take, good, push, full, empty;
  logic [7:0] din;
  assign pop_edge = pop && !pop_q;
  assign take = state == IDLE && rxready;
  assign push = take && good && (!full || pop_edge);
  assign valid = !empty;
  always_ff @(posedge hz100 or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pop_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      pop_q <= pop;
      if (take && good && full && !pop_edge) overflow <= 1'b1;
    end
  // WAIT_LOW holds off until rxready drops so a held byte is captured once
  always_comb begin
    state_nx = state;
    rxclk = 1'b0;
    state_nx = state == IDLE ? (rxready ? ACK : IDLE) :
               state == ACK  ? WAIT_LOW :
               (rxready ? WAIT_LOW : IDLE);
    rxclk = state == ACK;
  end
`ifdef RX_PARITY_EN
  assign good = ~^rxdata;
  assign din = {1'b0, rxdata[6:0]};
  always_ff @(posedge hz100 or negedge reset)
    if (!reset) perr <= 1'b0;
    else if (take && !good) perr <= 1'b1;
`else
  assign good = 1'b1;
  assign din = rxdata;
  assign perr = 1'b0;
`endif
  rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .hz100(hz100),
    .reset(reset),
    .push(push),
    .pop(pop_edge),
    .din(din),
    .dout(dout),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_rx_byte_buffer.sv
// tb_rx_byte_buffer: randomized scenario bench against a queue-based reference model
module tb_rx_byte_buffer;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  logic hz100 = 1'b0;
  logic reset = 1'b0, rxready = 1'b0, pop = 1'b0;
  logic [7:0] rxdata = 8'h00;
  logic rxclk, valid, overflow, perr;
  logic [7:0] dout;
  logic [CW-1:0] count;
  int errors = 0, checks = 0, pulses = 0;
  logic [7:0] q[$];
  logic m_ovf = 1'b0, m_perr = 1'b0;

  rx_byte_buffer #(.DEPTH(DEPTH)) dut (
    .hz100(hz100), .reset(reset), .rxdata(rxdata), .rxready(rxready), .rxclk(rxclk),
    .pop(pop), .dout(dout), .valid(valid), .count(count), .overflow(overflow), .perr(perr)
  );

  always #5 hz100 = ~hz100;
  always @(negedge hz100) if (rxclk === 1'b1) pulses++;

  function automatic logic parity_ok(input logic [7:0] b);
`ifdef RX_PARITY_EN
    return ($countones(b) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] stored(input logic [7:0] b);
`ifdef RX_PARITY_EN
    return b & 8'h7f;
`else
    return b;
`endif
  endfunction

  function automatic logic [7:0] exp_dout();
    return q.size() > 0 ? q[0] : 8'h00;
  endfunction

  task automatic do_reset();
    @(negedge hz100);
    reset = 1'b0; rxready = 1'b0; pop = 1'b0;
    q.delete(); m_ovf = 1'b0; m_perr = 1'b0;
    @(negedge hz100);
    reset = 1'b1;
  endtask

  // one sender transaction: byte offered for hold cycles, optional pop on the capture edge
  task automatic send(input logic [7:0] b, input int hold, input logic with_pop);
    bit full;
    @(negedge hz100);
    rxdata = b; rxready = 1'b1; pop = with_pop;
    @(posedge hz100);
    full = q.size() == DEPTH;
    if (with_pop && q.size() > 0) void'(q.pop_front());
    if (!parity_ok(b)) m_perr = 1'b1;
    else if (full && !with_pop) m_ovf = 1'b1;
    else q.push_back(stored(b));
    @(negedge hz100);
    pop = 1'b0;
    repeat (hold - 1) @(negedge hz100);
    rxready = 1'b0; rxdata = 8'($urandom);
    repeat (2) @(posedge hz100);
    @(negedge hz100);
  endtask

  task automatic do_pop(input int hold);
    @(negedge hz100);
    pop = 1'b1;
    @(posedge hz100);
    if (q.size() > 0) void'(q.pop_front());
    repeat (hold - 1) @(posedge hz100);
    @(negedge hz100);
    pop = 1'b0;
    @(posedge hz100);
    @(negedge hz100);
  endtask

  task automatic test_reset();
    #3;
    checks++; if (rxclk !== 1'b0) begin errors++; $display("FAIL reset_rxclk: got %b want 0", rxclk); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
    checks++; if (overflow !== 1'b0 || perr !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b perr=%b want 0 0", overflow, perr); end
  endtask

  task automatic test_single();
    int p0;
    do_reset();
    p0 = pulses;
    @(negedge hz100);
    checks++; if (rxclk !== 1'b0) begin errors++; $display("FAIL single_idle_rxclk: got %b want 0", rxclk); end
    rxdata = 8'hA5; rxready = 1'b1;
    @(posedge hz100);
    q.push_back(8'hA5);
    @(negedge hz100);
    checks++; if (rxclk !== 1'b1) begin errors++; $display("FAIL single_ack: got %b want 1", rxclk); end
    checks++; if (count !== CW'(1) || dout !== 8'hA5) begin errors++; $display("FAIL single_write: got count=%0d dout=%h want 1 a5", count, dout); end
    @(negedge hz100);
    checks++; if (rxclk !== 1'b0) begin errors++; $display("FAIL single_ack_end: got %b want 0", rxclk); end
    @(negedge hz100);
    rxready = 1'b0;
    repeat (3) @(negedge hz100);
    checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", pulses - p0); end
    checks++; if (count !== CW'(1) || dout !== 8'hA5 || valid !== 1'b1) begin errors++; $display("FAIL single_final: got count=%0d dout=%h valid=%b want 1 a5 1", count, dout, valid); end
  endtask

  task automatic test_fill_overflow();
    int p0;
    logic [7:0] e;
    do_reset();
    p0 = pulses;
    for (int b = 1; b <= 5; b++) send(8'(b), 1 + int'($urandom_range(2)), 1'b0);
    checks++; if (pulses - p0 != 5) begin errors++; $display("FAIL fill_pulses: got %0d want 5", pulses - p0); end
    checks++; if (count !== CW'(q.size())) begin errors++; $display("FAIL fill_count: got %0d want %0d", count, q.size()); end
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL fill_overflow: got %b want %b", overflow, m_ovf); end
    for (int i = 0; i < 4; i++) begin
      e = exp_dout();
      checks++; if (dout !== e) begin errors++; $display("FAIL fill_pop%0d: got %h want %h", i, dout, e); end
      do_pop(1);
    end
    checks++; if (valid !== 1'b0 || dout !== 8'h00) begin errors++; $display("FAIL fill_empty: got valid=%b dout=%h want 0 00", valid, dout); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    send(8'h11, 1, 1'b0); send(8'h22, 2, 1'b0); send(8'h33, 1, 1'b0); send(8'h44, 3, 1'b0);
    send(8'h77, 2, 1'b1);
    checks++; if (count !== CW'(q.size())) begin errors++; $display("FAIL simul_count: got %0d want %0d", count, q.size()); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow: got %b want 0", overflow); end
    checks++; if (dout !== exp_dout()) begin errors++; $display("FAIL simul_head: got %h want %h", dout, exp_dout()); end
    repeat (3) do_pop(1);
    checks++; if (dout !== 8'h77 || count !== CW'(1)) begin errors++; $display("FAIL simul_last: got dout=%h count=%0d want 77 1", dout, count); end
  endtask

  task automatic test_pop_held();
    do_reset();
    send(8'h11, 1, 1'b0); send(8'h22, 1, 1'b0); send(8'h33, 1, 1'b0);
    do_pop(10);
    checks++; if (count !== CW'(2) || dout !== 8'h22) begin errors++; $display("FAIL held_advance: got count=%0d dout=%h want 2 22", count, dout); end
    do_pop(1); do_pop(2);
    do_pop(4);
    checks++; if (count !== '0 || valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL held_empty_pop: got count=%0d valid=%b ovf=%b want 0 0 0", count, valid, overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h55, 1, 1'b0); send(8'h66, 1, 1'b0); send(8'h99, 1, 1'b0); send(8'hAA, 1, 1'b0); send(8'h3C, 1, 1'b0);
    repeat (3) do_pop(1);
    @(negedge hz100);
    rxdata = 8'h5A; rxready = 1'b1;
    @(posedge hz100);
    #1;
    checks++; if (rxclk !== 1'b1 || count !== CW'(2) || overflow !== 1'b1) begin errors++; $display("FAIL mid_pre: got rxclk=%b count=%0d ovf=%b want 1 2 1", rxclk, count, overflow); end
    #1 reset = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0; m_perr = 1'b0;
    checks++; if (rxclk !== 1'b0 || count !== '0 || valid !== 1'b0 || dout !== 8'h00) begin errors++; $display("FAIL mid_async: got rxclk=%b count=%0d valid=%b dout=%h want 0 0 0 00", rxclk, count, valid, dout); end
    checks++; if (overflow !== 1'b0 || perr !== 1'b0) begin errors++; $display("FAIL mid_flags: got ovf=%b perr=%b want 0 0", overflow, perr); end
    @(negedge hz100);
    reset = 1'b1;
    @(posedge hz100);
    q.push_back(8'h5A);
    @(negedge hz100);
    rxready = 1'b0;
    checks++; if (rxclk !== 1'b1 || count !== CW'(1) || dout !== 8'h5A) begin errors++; $display("FAIL mid_redeliver: got rxclk=%b count=%0d dout=%h want 1 1 5a", rxclk, count, dout); end
    repeat (2) @(posedge hz100);
  endtask

  task automatic test_parity();
    int p0;
    do_reset();
    p0 = pulses;
    send(8'h03, 1, 1'b0);
    send(8'h83, 2, 1'b0);
    checks++; if (pulses - p0 != 2) begin errors++; $display("FAIL parity_pulses: got %0d want 2", pulses - p0); end
    checks++; if (dout !== 8'h03) begin errors++; $display("FAIL parity_head: got %h want 03", dout); end
    checks++; if (count !== CW'(q.size()) || perr !== m_perr) begin errors++; $display("FAIL parity_state: got count=%0d perr=%b want %0d %b", count, perr, q.size(), m_perr); end
  endtask

  task automatic test_random();
    int p0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(2) != 0) begin
        p0 = pulses;
        send(8'($urandom), 1 + int'($urandom_range(3)), 1'($urandom_range(1)));
        checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL rand_pulse%0d: got %0d want 1", i, pulses - p0); end
      end else do_pop(1 + int'($urandom_range(2)));
      checks++;
      if (count !== CW'(q.size()) || dout !== exp_dout() || valid !== (q.size() > 0) || overflow !== m_ovf || perr !== m_perr) begin
        errors++;
        $display("FAIL rand_state%0d: got count=%0d dout=%h valid=%b ovf=%b perr=%b want %0d %h %b %b %b",
                 i, count, dout, valid, overflow, perr, q.size(), exp_dout(), q.size() > 0, m_ovf, m_perr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_simultaneous();
    test_pop_held();
    test_reset_mid();
    test_parity();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
